// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer in front of a combinational 16-bit ALU: builds N-bit shifts and
// shift-add multiply by iterating on the ALU, and returns results over valid/ready.
module alu_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [2:0]       req_func,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_func,
    input  logic [WIDTH-1:0] alu_r,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zf
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    localparam logic [1:0] OpShl    = 2'b00;
    localparam logic [1:0] OpShr    = 2'b01;
    localparam logic [1:0] OpMul    = 2'b10;
    localparam logic [1:0] OpSingle = 2'b11;

    localparam logic [2:0] FuncAdd = 3'b000;
    localparam logic [2:0] FuncShl = 3'b110;
    localparam logic [2:0] FuncShr = 3'b111;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [2:0]       func_q, func_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] m_q, m_d;
    // Shift count for SHLN/SHRN, multiplier for MUL.
    logic [WIDTH-1:0] q_q, q_d;
    logic             phase_q, phase_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_zf_q, res_zf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= 2'b00;
            func_q     <= 3'b000;
            acc_q      <= '0;
            m_q        <= '0;
            q_q        <= '0;
            phase_q    <= 1'b0;
            res_data_q <= '0;
            res_zf_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            func_q     <= func_d;
            acc_q      <= acc_d;
            m_q        <= m_d;
            q_q        <= q_d;
            phase_q    <= phase_d;
            res_data_q <= res_data_d;
            res_zf_q   <= res_zf_d;
        end
    end

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_func = FuncAdd;
        if (state_q == StRun) begin
            unique case (op_q)
                OpShl: begin
                    alu_a    = acc_q;
                    alu_func = FuncShl;
                end
                OpShr: begin
                    alu_a    = acc_q;
                    alu_func = FuncShr;
                end
                OpMul: begin
                    if (!phase_q) begin
                        alu_a    = acc_q;
                        alu_b    = m_q;
                        alu_func = FuncAdd;
                    end else begin
                        alu_a    = m_q;
                        alu_func = FuncShl;
                    end
                end
                default: begin
                    alu_a    = acc_q;
                    alu_b    = m_q;
                    alu_func = func_q;
                end
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        func_d     = func_q;
        acc_d      = acc_q;
        m_d        = m_q;
        q_d        = q_q;
        phase_d    = phase_q;
        res_data_d = res_data_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d    = req_op;
                    func_d  = req_func;
                    phase_d = 1'b0;
                    unique case (req_op)
                        OpShl, OpShr: begin
                            acc_d = req_a;
                            q_d   = {{(WIDTH-SHAMT_W){1'b0}}, req_b[SHAMT_W-1:0]};
                            if (req_b[SHAMT_W-1:0] == '0) begin
                                state_d    = StDone;
                                res_data_d = req_a;
                            end else begin
                                state_d = StRun;
                            end
                        end
                        OpMul: begin
                            acc_d = '0;
                            m_d   = req_a;
                            q_d   = req_b;
                            if (req_b == '0) begin
                                state_d    = StDone;
                                res_data_d = '0;
                            end else begin
                                state_d = StRun;
                            end
                        end
                        default: begin
                            acc_d   = req_a;
                            m_d     = req_b;
                            state_d = StRun;
                        end
                    endcase
                end
            end
            StRun: begin
                unique case (op_q)
                    OpShl, OpShr: begin
                        acc_d = alu_r;
                        q_d   = q_q - WIDTH'(1);
                        if (q_q == WIDTH'(1)) begin
                            state_d    = StDone;
                            res_data_d = alu_r;
                        end
                    end
                    OpMul: begin
                        if (!phase_q) begin
                            if (q_q[0]) begin
                                acc_d = alu_r;
                            end
                            phase_d = 1'b1;
                        end else begin
                            m_d     = alu_r;
                            q_d     = q_q >> 1;
                            phase_d = 1'b0;
                            if ((q_q >> 1) == '0) begin
                                state_d    = StDone;
                                res_data_d = acc_q;
                            end
                        end
                    end
                    default: begin
                        state_d    = StDone;
                        res_data_d = alu_r;
                    end
                endcase
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // res_data_d only differs from res_data_q on entry to DONE.
        res_zf_d = ~|res_data_d;
    end

    assign req_ready = (state_q == StIdle);
    assign res_valid = (state_q == StDone);
    assign res_data  = res_data_q;
    assign res_zf    = res_zf_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases plus randomized requests checked
// against an arithmetic reference model, with an ALU model closing the loop.
module tb_alu_sequencer;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [2:0]       req_func;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_func;
    logic [WIDTH-1:0] alu_r;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_zf;

    int n_checks = 0;
    int n_fail   = 0;
    int shl_cycles;
    int busy_cycles;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(WIDTH), .SHAMT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_func  (req_func),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_func  (alu_func),
        .alu_r     (alu_r),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zf    (res_zf)
    );

    function automatic logic [WIDTH-1:0] alu_fn(logic [2:0] f, logic [WIDTH-1:0] a,
                                                logic [WIDTH-1:0] b);
        case (f)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return ~(a | b);
            3'b101:  return a ^ b;
            3'b110:  return a << 1;
            default: return a >> 1;
        endcase
    endfunction

    always_comb alu_r = alu_fn(alu_func, alu_a, alu_b);

    // Reference result from the operation's meaning, not from the iteration.
    function automatic logic [WIDTH-1:0] ref_data(logic [1:0] op, logic [2:0] f,
                                                  logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        logic [31:0] prod;
        case (op)
            2'b00:   return a << b[3:0];
            2'b01:   return a >> b[3:0];
            2'b10: begin
                prod = 32'(a) * 32'(b);
                return prod[WIDTH-1:0];
            end
            default: return alu_fn(f, a, b);
        endcase
    endfunction

    function automatic int ref_lat(logic [1:0] op, logic [WIDTH-1:0] b);
        int k = 0;
        case (op)
            2'b00, 2'b01: return (b[3:0] == 4'd0) ? 1 : int'(b[3:0]) + 1;
            2'b10: begin
                for (int i = 0; i < WIDTH; i++) if (b[i]) k = i + 1;
                return (k == 0) ? 1 : 2 * k + 1;
            end
            default: return 2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for res_valid, check latency/data/zf.
    // Leaves the bench one cycle into DONE, #1 after the edge, res_ready low.
    task automatic issue(input logic [1:0] op, input logic [2:0] f, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
        int lat;
        logic [WIDTH-1:0] exp_d;
        exp_d = ref_data(op, f, a, b);
        check("req_ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_func  = f;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        req_a       = $urandom;
        req_b       = $urandom;
        lat         = 1;
        shl_cycles  = 0;
        busy_cycles = 0;
        while (!res_valid && lat < 200) begin
            if (alu_func == 3'b110) shl_cycles++;
            if (alu_func != 3'b000 || alu_a != '0) busy_cycles++;
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(ref_lat(op, b)));
        check("res_data", 32'(res_data), 32'(exp_d));
        check("res_zf", 32'(res_zf), 32'(exp_d == '0));
    endtask

    task automatic take();
        check("req_ready_in_done", 32'(req_ready), 32'd0);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("res_valid_after_take", 32'(res_valid), 32'd0);
        check("req_ready_after_take", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [1:0]       op;
        logic [WIDTH-1:0] a, b, held;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_func  = 3'b000;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_zf", 32'(res_zf), 32'd1);
        check("rst_alu_func", 32'(alu_func), 32'd0);

        issue(2'b00, 3'b000, 16'h0003, 16'd4);
        check("shln_shl_cycles", 32'(shl_cycles), 32'd4);
        take();
        check("data_kept_in_idle", 32'(res_data), 32'h0030);
        issue(2'b01, 3'b000, 16'h8000, 16'd15);
        take();
        issue(2'b01, 3'b000, 16'h1234, 16'd0);
        check("shrn0_alu_idle", 32'(busy_cycles), 32'd0);
        take();
        issue(2'b10, 3'b000, 16'h0012, 16'h0005);
        take();
        issue(2'b10, 3'b000, 16'h0100, 16'h0100);
        take();
        issue(2'b10, 3'b000, 16'hFFFF, 16'h0000);
        take();
        issue(2'b11, 3'b001, 16'd5, 16'd5);
        take();
        issue(2'b11, 3'b100, 16'd0, 16'd0);
        take();

        // Stall in DONE with a stray request that must be ignored.
        issue(2'b00, 3'b000, 16'h00F1, 16'd3);
        held = 16'h0788;
        for (int i = 0; i < 3; i++) begin
            req_valid = (i == 1);
            req_op    = 2'b11;
            req_func  = 3'b100;
            req_a     = '0;
            req_b     = '0;
            @(posedge clk);
            #1;
            check("hold_res_valid", 32'(res_valid), 32'd1);
            check("hold_res_data", 32'(res_data), 32'(held));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        take();
        @(posedge clk);
        #1;
        check("stray_not_run", 32'(res_valid), 32'd0);
        check("stray_data_kept", 32'(res_data), 32'(held));

        // Abort a long multiply with reset.
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_a     = 16'hFFFF;
        req_b     = 16'hFFFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_alu_a", 32'(alu_a), 32'd0);
        check("abort_alu_b", 32'(alu_b), 32'd0);
        check("abort_alu_func", 32'(alu_func), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_result", 32'(res_valid), 32'd0);
        issue(2'b00, 3'b000, 16'h0001, 16'd9);
        take();

        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if (op == 2'b10) b = b & 16'((32'd1 << $urandom_range(0, 16)) - 1);
            issue(op, 3'($urandom_range(0, 7)), a, b);
            take();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
